// File: rtl/r_skid_monitor.sv
// r_skid_monitor
//   Two-entry register slice for an AXI-style R channel with a burst monitor
//   watching the downstream side. Every output comes straight from a flop;
//   s_ready is a function of the buffer state only, never of m_ready.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_valid/s_id/s_data/s_resp/s_last   upstream R beat from the slave
//   s_ready        upstream accept
//   m_valid/m_id/m_data/m_resp/m_last   downstream R beat to the master
//   m_ready        downstream accept
//   burst_done     one-cycle pulse after a last beat is accepted downstream
//   burst_id       ID of the completed burst (valid with burst_done)
//   burst_beats    saturating beat count of the completed burst
//   burst_err      some beat of the completed burst had a non-zero response
//   interleave_err sticky: downstream ID changed in the middle of a burst
module r_skid_monitor #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [ID_WIDTH-1:0]   s_id,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [RESP_WIDTH-1:0] s_resp,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [ID_WIDTH-1:0]   m_id,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [RESP_WIDTH-1:0] m_resp,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  burst_done,
    output logic [ID_WIDTH-1:0]   burst_id,
    output logic [CNT_WIDTH-1:0]  burst_beats,
    output logic                  burst_err,
    output logic                  interleave_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Saturating increment of the beat counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_WIDTH'(1'b1);
        end
        return r;
    endfunction

    state_t                state_r;
    logic                  s_ready_r;
    logic                  m_valid_r;

    // OUT register: the beat presented downstream
    logic [ID_WIDTH-1:0]   out_id_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [RESP_WIDTH-1:0] out_resp_r;
    logic                  out_last_r;

    // SKID register: the beat caught while OUT was stalled
    logic [ID_WIDTH-1:0]   skid_id_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic [RESP_WIDTH-1:0] skid_resp_r;
    logic                  skid_last_r;

    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  err_r;
    logic [ID_WIDTH-1:0]   start_id_r;
    logic                  burst_done_r;
    logic [ID_WIDTH-1:0]   burst_id_r;
    logic [CNT_WIDTH-1:0]  burst_beats_r;
    logic                  burst_err_r;
    logic                  ierr_r;

    logic                  up_hs_s;
    logic                  dn_hs_s;
    logic                  resp_nz_s;

    assign up_hs_s   = s_valid & s_ready_r;
    assign dn_hs_s   = m_valid_r & m_ready;
    assign resp_nz_s = (out_resp_r != {RESP_WIDTH{1'b0}});

    // Slice FSM: state, handshake flags and the OUT/SKID payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            s_ready_r   <= 1'b0;
            m_valid_r   <= 1'b0;
            out_id_r    <= {ID_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_resp_r  <= {RESP_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            skid_id_r   <= {ID_WIDTH{1'b0}};
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_resp_r <= {RESP_WIDTH{1'b0}};
            skid_last_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    // s_ready is low only for the first cycle after reset
                    s_ready_r <= 1'b1;
                    if (up_hs_s) begin
                        out_id_r   <= s_id;
                        out_data_r <= s_data;
                        out_resp_r <= s_resp;
                        out_last_r <= s_last;
                        m_valid_r  <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                ONE: begin
                    if (up_hs_s && dn_hs_s) begin
                        out_id_r   <= s_id;
                        out_data_r <= s_data;
                        out_resp_r <= s_resp;
                        out_last_r <= s_last;
                    end else if (up_hs_s) begin
                        skid_id_r   <= s_id;
                        skid_data_r <= s_data;
                        skid_resp_r <= s_resp;
                        skid_last_r <= s_last;
                        s_ready_r   <= 1'b0;
                        state_r     <= FULL;
                    end else if (dn_hs_s) begin
                        m_valid_r <= 1'b0;
                        state_r   <= EMPTY;
                    end
                end
                FULL: begin
                    if (dn_hs_s) begin
                        out_id_r   <= skid_id_r;
                        out_data_r <= skid_data_r;
                        out_resp_r <= skid_resp_r;
                        out_last_r <= skid_last_r;
                        s_ready_r  <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                default: begin
                    s_ready_r <= 1'b0;
                    m_valid_r <= 1'b0;
                    state_r   <= EMPTY;
                end
            endcase
        end
    end

    // Burst monitor: counts downstream beats, reports completion, flags interleave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= {CNT_WIDTH{1'b0}};
            err_r         <= 1'b0;
            start_id_r    <= {ID_WIDTH{1'b0}};
            burst_done_r  <= 1'b0;
            burst_id_r    <= {ID_WIDTH{1'b0}};
            burst_beats_r <= {CNT_WIDTH{1'b0}};
            burst_err_r   <= 1'b0;
            ierr_r        <= 1'b0;
        end else begin
            burst_done_r <= 1'b0;
            if (dn_hs_s) begin
                // A zero counter marks the first beat of a burst; its ID is the reference
                if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                    start_id_r <= out_id_r;
                end else if (out_id_r != start_id_r) begin
                    ierr_r <= 1'b1;
                end
                if (out_last_r) begin
                    burst_done_r  <= 1'b1;
                    burst_beats_r <= sat_inc(cnt_r);
                    burst_id_r    <= out_id_r;
                    burst_err_r   <= err_r | resp_nz_s;
                    cnt_r         <= {CNT_WIDTH{1'b0}};
                    err_r         <= 1'b0;
                end else begin
                    cnt_r <= sat_inc(cnt_r);
                    err_r <= err_r | resp_nz_s;
                end
            end
        end
    end

    assign s_ready        = s_ready_r;
    assign m_valid        = m_valid_r;
    assign m_id           = out_id_r;
    assign m_data         = out_data_r;
    assign m_resp         = out_resp_r;
    assign m_last         = out_last_r;
    assign burst_done     = burst_done_r;
    assign burst_id       = burst_id_r;
    assign burst_beats    = burst_beats_r;
    assign burst_err      = burst_err_r;
    assign interleave_err = ierr_r;

endmodule

// File: doc/r_skid_monitor.md
R_SKID_MONITOR -- requirements
Module: r_skid_monitor

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data payload width.
REQ-003 SHALL have parameter RESP_WIDTH, default 2, response code width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, burst beat counter width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have ports s_valid/s_id/s_data/s_resp/s_last  input  1/ID_WIDTH/DATA_WIDTH/RESP_WIDTH/1  upstream R beat from the slave.
REQ-009 SHALL have port s_ready  output  1  upstream accept.
REQ-010 SHALL have ports m_valid/m_id/m_data/m_resp/m_last  output  1/ID_WIDTH/DATA_WIDTH/RESP_WIDTH/1  downstream R beat to the master.
REQ-011 SHALL have port m_ready  input  1  downstream accept.
REQ-012 SHALL have port burst_done  output  1  one-cycle pulse when a last beat is accepted downstream.
REQ-013 SHALL have port burst_id  output  ID_WIDTH  ID of the completed burst, valid with burst_done.
REQ-014 SHALL have port burst_beats  output  CNT_WIDTH  beat count of the completed burst, valid with burst_done.
REQ-015 SHALL have port burst_err  output  1  any beat in the completed burst had resp != 0, valid with burst_done.
REQ-016 SHALL have port interleave_err  output  1  sticky flag: downstream ID changed mid-burst.

Function
REQ-017 SHALL be a 2-entry register slice: output register (OUT) plus skid register (SKID); all outputs registered; s_ready SHALL NOT depend combinationally on m_ready.
REQ-018 SHALL use FSM states EMPTY (no data), ONE (OUT valid), FULL (OUT and SKID valid).
REQ-019 Upstream handshake = s_valid & s_ready; downstream handshake = m_valid & m_ready.
REQ-020 s_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL; m_valid SHALL be 1 in ONE and FULL.
REQ-021 EMPTY + upstream hs -> ONE; beat loads OUT; m_valid rises on the next cycle (latency 1).
REQ-022 ONE + upstream hs with no downstream hs -> FULL; beat loads SKID.
REQ-023 ONE + both hs -> stay ONE; new beat loads OUT.
REQ-024 ONE + downstream hs only -> EMPTY.
REQ-025 FULL + downstream hs -> ONE; SKID moves to OUT.
REQ-026 Beat order SHALL be preserved; no beat dropped or duplicated; all payload fields SHALL move together.
REQ-027 m_* payload SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 Beat counter SHALL increment on each downstream hs and saturate at 2^CNT_WIDTH-1.
REQ-029 On a downstream hs with m_last=1, next cycle: burst_done=1, burst_beats=counter+1 (saturating), burst_id=m_id, burst_err=(sticky err | m_resp!=0); counter and sticky err SHALL clear in the same cycle.
REQ-030 A first beat and its last beat in the same handshake (single-beat burst) SHALL report burst_beats=1.
REQ-031 burst_done SHALL be 0 in all other cycles; burst_id/beats/err SHALL hold their last values.
REQ-032 On a downstream hs with counter!=0 and m_id != ID latched at burst start, interleave_err SHALL set and stay 1 until reset; counting SHALL continue.

Reset
REQ-033 On rst_n=0, asynchronously: state=EMPTY, s_ready=0, m_valid=0, m_id/m_data/m_resp/m_last=0, counter=0, burst_done=0, burst_id=0, burst_beats=0, burst_err=0, interleave_err=0.
REQ-034 s_ready SHALL go to 1 on the first rising clk after rst_n deasserts; reset mid-burst SHALL discard buffered beats and partial counts.

Verification
REQ-035 Single beat: id=3, data=0xA5, resp=0, last=1, m_ready=1 -> m_valid next cycle with same fields; burst_done one cycle later, burst_beats=1, burst_id=3, burst_err=0.
REQ-036 Backpressure: m_ready=0, 3 beats offered -> 2 accepted, s_ready=0 after the 2nd; m_ready=1 -> beats out in order, no loss.
REQ-037 Streaming: 4-beat burst id=5, m_ready=1 continuously -> one beat per cycle; burst_beats=4; beat 3 resp=2 -> burst_err=1.
REQ-038 Interleave: id=1 non-last beat, then id=2 beat -> interleave_err=1 and stays 1 through later clean bursts.
REQ-039 Saturation: CNT_WIDTH=2, 6-beat burst -> burst_beats=3.
REQ-040 Reset in FULL: assert rst_n=0 -> m_valid=0 and s_ready=0 immediately; after release, no stale beat appears and the counter is 0.
